alu_mc: RTL
===========

# alu_mc

Parametrised multi-cycle ALU for the MIPS datapath's EX stage. It keeps the single-cycle operation set and adds several new operations:
- logic/shift/compare operations (xor, nor, sll, srl, sra, sltu), finished in one registered cycle;
- iterative multiply and divide (signed and unsigned) writing HI/LO registers.

A valid/ready handshake lets the control unit stall the pipeline while a multi-cycle operation runs.

## Interface
- WIDTH, 32, operand/result width; must be ≥ 4 and a power of two
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  operation request
- in_ready  out  1  block can accept; 1 only in IDLE and rst_n high
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B; shifts use b[$clog2(WIDTH)-1:0] as shift amount, shifting a
- ctrl  in  4  operation code
- out_valid  out  1  one-cycle pulse; result/zero/overflow valid
- result  out  WIDTH  operation result; for mult/div it equals the new LO
- zero  out  1  registered (a == b) of the accepted operands
- overflow  out  1  signed overflow of add/sub; 0 for all other ops
- hi  out  WIDTH  HI register (product high half / remainder)
- lo  out  WIDTH  LO register (product low half / quotient)

## Operation
- ctrl encoding:
  - single-cycle ops: 0000 and, 0001 or, 0010 add, 0011 xor, 0100 nor, 0101 sltu, 0110 sub, 0111 slt, 1000 sll, 1001 srl, 1010 sra;
  - multi-cycle ops: 1100 mult, 1101 multu, 1110 div, 1111 divu;
  - 1011 reserved: result 0, single-cycle.
- Accept = in_valid & in_ready; operands and ctrl are captured on accept.
- add/sub wrap modulo 2^WIDTH; overflow = operand signs equal (after B negation for sub) and result sign differs.
- slt/sltu: result = {WIDTH-1 zeros, flag}.
- FSM states:
  - IDLE: single-cycle op → result registered, stays IDLE; mult/multu → MUL; div/divu → DIV.
  - MUL: WIDTH shift-add iterations on operand magnitudes → FIX.
  - DIV: WIDTH restoring-division iterations on magnitudes → FIX.
  - FIX: negate per sign rules, write HI/LO/result, pulse out_valid → IDLE.
- Signed sign rules:
  - product negated if signs differ;
  - quotient negated if signs differ;
  - remainder takes the dividend's sign.
- Divide by zero: no trap. Unsigned → lo = all ones, hi = a. Signed → lo = (a<0 ? 1 : all ones), hi = a.
- Most-negative / −1 signed divide: lo = a, hi = 0 (wraps).
- hi/lo change only in FIX; single-cycle ops never touch them.
- No output backpressure: out_valid is a pulse and the consumer must take it.

## Timing
- Reset (rst_n low at a clk edge):
  - state IDLE;
  - result, hi, lo = 0; zero, overflow, out_valid = 0;
  - in_ready = 0 while rst_n is low.
- Single-cycle op accepted at edge T: out_valid high in cycle T+1. Back-to-back accepts every cycle are allowed.
- Multi-cycle op accepted at edge T:
  - in_ready = 0 from T+1;
  - out_valid, hi, lo, result are updated at edge T+WIDTH+2;
  - in_ready returns to 1 in that same cycle, so the next accept can occur on the following edge.
- in_valid while busy is ignored (not queued); operand changes while busy have no effect.
- Reset mid-operation aborts on the next edge: no out_valid, hi/lo cleared.
- Iteration counter is $clog2(WIDTH)+1 bits and does not wrap.

## Structure
- Package alu_pkg holds:
  - ctrl opcode localparams (ALU_AND … ALU_DIVU);
  - FSM state typedef (IDLE, MUL, DIV, FIX).
- Sub-module alu_muldiv (WIDTH parameter) holds the iterative datapath: magnitude conversion, shift-add/restoring loop, counter and sign fix. It has a start/done interface.
- Top level alu_mc holds the single-cycle ops, handshake, output registers and HI/LO.

## Test plan
- Reset held 2 cycles, then release → all outputs 0, in_ready 1; accept add a=7, b=5 → next cycle result 12, zero 0, out_valid pulse.
- add a=0x7FFFFFFF, b=1 → result 0x80000000, overflow 1; sub a=5, b=5 → result 0, zero 1, overflow 0.
- sra a=0x80000000, b=4 → 0xF8000000; srl same operands → 0x08000000; slt a=−1, b=1 → 1; sltu same → 0.
- mult a=−3, b=7 → out_valid exactly 34 cycles after accept, hi=0xFFFFFFFF, lo=0xFFFFFFEB; multu 0xFFFFFFFF² → hi=0xFFFFFFFE, lo=1.
- div a=−7, b=2 → lo=−3, hi=−1; divu a=9, b=0 → lo=0xFFFFFFFF, hi=9; in_valid held during busy → no extra out_valid.
- rst_n dropped mid-mult → no out_valid, hi=lo=0, in_ready 1 after release; WIDTH=8 rerun of mult → 10-cycle latency.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_mc shared definitions: opcode encodings and the control FSM state type.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_NOR  = 4'b0100;
    localparam logic [3:0] ALU_SLTU = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLL  = 4'b1000;
    localparam logic [3:0] ALU_SRL  = 4'b1001;
    localparam logic [3:0] ALU_SRA  = 4'b1010;
    localparam logic [3:0] ALU_RSVD = 4'b1011;
    localparam logic [3:0] ALU_MULT = 4'b1100;
    localparam logic [3:0] ALU_MULTU = 4'b1101;
    localparam logic [3:0] ALU_DIV  = 4'b1110;
    localparam logic [3:0] ALU_DIVU = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } state_t;

endpackage

// File: rtl/alu_muldiv.sv
// Iterative multiply / restoring divide on operand magnitudes with sign fix-up.
// Latency: loads on start, done WIDTH edges later; hi/lo stay valid until next start.
// Backpressure: none; the owner must not pulse start while an operation is in flight.
module alu_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_div,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] CNT_END = CW'(WIDTH);

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] mb;
    logic [CW-1:0]    cnt;
    logic             div_r;
    logic             neg_q;
    logic             neg_r;

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   shl;
    logic [WIDTH:0]   sub_diff;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;

    assign a_neg = is_signed & a[WIDTH-1];
    assign b_neg = is_signed & b[WIDTH-1];
    // Most-negative magnitude still fits as an unsigned WIDTH-bit value.
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;

    assign add_sum  = {1'b0, acc} + {1'b0, mb};
    assign shl      = {acc, q[WIDTH-1]};
    assign sub_diff = shl - {1'b0, mb};

    assign done = (cnt == CNT_END);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc   <= '0;
            q     <= '0;
            mb    <= '0;
            cnt   <= CNT_END;
            div_r <= 1'b0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (start) begin
            acc   <= '0;
            q     <= a_mag;
            mb    <= b_mag;
            cnt   <= '0;
            div_r <= is_div;
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
        end else if (!done) begin
            cnt <= cnt + 1'b1;
            if (div_r) begin
                // Restoring step: keep the shifted partial remainder on borrow.
                if (!sub_diff[WIDTH]) begin
                    acc <= sub_diff[WIDTH-1:0];
                    q   <= {q[WIDTH-2:0], 1'b1};
                end else begin
                    acc <= shl[WIDTH-1:0];
                    q   <= {q[WIDTH-2:0], 1'b0};
                end
            end else if (q[0]) begin
                {acc, q} <= {add_sum, q[WIDTH-1:1]};
            end else begin
                {acc, q} <= {1'b0, acc, q[WIDTH-1:1]};
            end
        end
    end

    // Divide-by-zero and MIN/-1 fall out of the magnitude loop and sign rules.
    assign prod     = {acc, q};
    assign prod_fix = neg_q ? -prod : prod;
    assign hi = div_r ? (neg_r ? -acc : acc) : prod_fix[2*WIDTH-1:WIDTH];
    assign lo = div_r ? (neg_q ? -q : q)     : prod_fix[WIDTH-1:0];

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle EX-stage ALU: registered single-cycle ops plus iterative mult/div into HI/LO.
// Latency: single-cycle ops 1 edge; mult/div WIDTH+2 edges from accept.
// Backpressure: in_ready low while mult/div runs; outputs are pulses with no backpressure.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       ctrl,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int SW = $clog2(WIDTH);

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic             is_mc;
    logic             start;
    logic             fix_en;
    logic             md_done;
    logic [WIDTH-1:0] md_hi;
    logic [WIDTH-1:0] md_lo;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [SW-1:0]    shamt;
    logic [WIDTH-1:0] sc_res;
    logic             sc_ovf;

    assign accept = in_valid & in_ready;
    assign is_mc  = (ctrl[3:2] == ALU_MULT[3:2]);
    assign start  = accept & is_mc;
    assign sum    = a + b;
    assign diff   = a - b;
    assign shamt  = b[SW-1:0];

    always_comb begin
        sc_res = '0;
        sc_ovf = 1'b0;
        case (ctrl)
            ALU_AND:  sc_res = a & b;
            ALU_OR:   sc_res = a | b;
            ALU_ADD: begin
                sc_res = sum;
                sc_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_XOR:  sc_res = a ^ b;
            ALU_NOR:  sc_res = ~(a | b);
            ALU_SLTU: sc_res = {{(WIDTH-1){1'b0}}, (a < b)};
            ALU_SUB: begin
                sc_res = diff;
                sc_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLL:  sc_res = a << shamt;
            ALU_SRL:  sc_res = a >> shamt;
            ALU_SRA:  sc_res = WIDTH'($signed(a) >>> shamt);
            default:  sc_res = '0;
        endcase
    end

    alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .is_div    (ctrl[1]),
        .is_signed (~ctrl[0]),
        .a         (a),
        .b         (b),
        .done      (md_done),
        .hi        (md_hi),
        .lo        (md_lo)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ctrl[1] ? DIV : MUL;
            MUL,
            DIV:     if (md_done) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready = rst_n && (state == IDLE);
        fix_en   = (state == FIX);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result    <= '0;
            hi        <= '0;
            lo        <= '0;
            zero      <= 1'b0;
            overflow  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (accept) begin
                zero     <= (a == b);
                overflow <= sc_ovf;
                if (!is_mc) begin
                    result    <= sc_res;
                    out_valid <= 1'b1;
                end
            end
            if (fix_en) begin
                hi        <= md_hi;
                lo        <= md_lo;
                result    <= md_lo;
                out_valid <= 1'b1;
            end
        end
    end

endmodule
